// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle
// shared by the two ALU clients and the arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [5:0]         req_op;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational
// ALU between two requesters, one op in flight at a time.
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             last_grant;
    logic [WIDTH-1:0] result;
    logic             win;
    logic             accept;

    // Winner pick: lone requester wins, ties go away from last grant.
    always_comb begin
        win = 1'b0;
        case (bus.req_valid)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant;
            default: win = 1'b0;
        endcase
    end

    // Ready only for the winner, only in IDLE and out of reset.
    always_comb begin
        bus.req_ready = 2'b00;
        accept        = 1'b0;
        if (rst_n && state == IDLE && |bus.req_valid) begin
            bus.req_ready = win ? 2'b10 : 2'b01;
            accept        = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept -> one settle cycle -> hold until taken.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, result capture at end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= 3'b000;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            result     <= '0;
        end else begin
            if (accept) begin
                alu_a      <= win ? bus.req_a[WIDTH +: WIDTH]
                                  : bus.req_a[0 +: WIDTH];
                alu_b      <= win ? bus.req_b[WIDTH +: WIDTH]
                                  : bus.req_b[0 +: WIDTH];
                alu_s      <= win ? bus.req_op[5:3]
                                  : bus.req_op[2:0];
                owner      <= win;
                last_grant <= win;
            end
            if (state == EXEC) result <= alu_out;
        end
    end

    // Response and status decode from state and held result.
    always_comb begin
        bus.rsp_valid = 2'b00;
        if (state == RESP)
            bus.rsp_valid = owner ? 2'b10 : 2'b01;
        bus.rsp_data = result;
        bus.rsp_zero = (result == '0);
        busy         = (state != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors against a reference ALU
// hooked to the arbiter's registered operand outputs.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_out;
    logic       busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    alu_arbiter_if #(.WIDTH(8)) bus ();

    alu_arbiter #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_s   (alu_s),
        .alu_out (alu_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: ADD SUB AND OR XOR NOT SHL SHR.
    always_comb begin
        alu_out = 8'h00;
        case (alu_s)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = ~alu_a;
            3'd6: alu_out = alu_a << 1;
            default: alu_out = alu_a >> 1;
        endcase
    end

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h want %02h",
                     tag, got, exp);
        end
    endtask

    // One transaction from requester r, rsp_ready held at 11.
    task automatic do_op(input int r,
                         input logic [2:0] op,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [7:0] exp);
        logic [1:0] m;
        m = (r == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        bus.rsp_ready = 2'b11;
        bus.req_valid = m;
        bus.req_op    = (r == 0) ? {3'b000, op} : {op, 3'b000};
        bus.req_a     = (r == 0) ? {8'h00, a} : {a, 8'h00};
        bus.req_b     = (r == 0) ? {8'h00, b} : {b, 8'h00};
        #1;
        chk("ready", 8'(bus.req_ready), 8'(m));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("exec_busy", 8'(busy), 8'd1);
        chk("exec_rv", 8'(bus.rsp_valid), 8'd0);
        @(negedge clk);
        #1;
        chk("rsp_valid", 8'(bus.rsp_valid), 8'(m));
        chk("rsp_data", bus.rsp_data, exp);
        chk("rsp_zero", 8'(bus.rsp_zero), 8'(exp == 8'h00));
        @(negedge clk);
        #1;
        chk("idle_busy", 8'(busy), 8'd0);
    endtask

    logic [7:0] sweep [8] = '{8'hD2, 8'h5A, 8'h14, 8'hBE,
                              8'hAA, 8'h69, 8'h2C, 8'h4B};

    initial begin
        int seen;
        bus.req_valid = 2'b11;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 2'b00;

        // Reset state.
        #12;
        chk("rst_ready", 8'(bus.req_ready), 8'd0);
        chk("rst_rv", 8'(bus.rsp_valid), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_zero", 8'(bus.rsp_zero), 8'd1);
        chk("rst_data", bus.rsp_data, 8'h00);
        chk("rst_alus", 8'(alu_s), 8'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADD and opcode sweep.
        do_op(0, 3'd0, 8'h05, 8'h03, 8'h08);
        for (int i = 0; i < 8; i++)
            do_op(1, 3'(i), 8'h96, 8'h3C, sweep[i]);

        // Wrap and zero.
        do_op(0, 3'd1, 8'h00, 8'h01, 8'hFF);
        do_op(0, 3'd1, 8'h5A, 8'h5A, 8'h00);
        do_op(0, 3'd0, 8'hFF, 8'h01, 8'h00);

        // Contention from reset: 0,1,0,1 every 3 cycles.
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_op    = 6'b000_000;
        bus.req_a     = {8'h02, 8'h01};
        bus.req_b     = {8'h02, 8'h01};
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [1:0] g;
            g = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("ct_ready", 8'(bus.req_ready),
                (i % 3 == 0) ? 8'(g) : 8'd0);
            chk("ct_rv", 8'(bus.rsp_valid),
                (i % 3 == 2) ? 8'(g) : 8'd0);
            if (i % 3 == 2)
                chk("ct_data", bus.rsp_data,
                    (g == 2'b01) ? 8'h02 : 8'h04);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;

        // Backpressure, with non-owner rsp_ready ignored.
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b01;
        bus.req_op    = 6'b000_100;
        bus.req_a     = 16'h00F0;
        bus.req_b     = 16'h000F;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        bus.req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rv", 8'(bus.rsp_valid), 8'd1);
            chk("bp_data", bus.rsp_data, 8'hFF);
            chk("bp_ready", 8'(bus.req_ready), 8'd0);
            chk("bp_busy", 8'(busy), 8'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        chk("bp_idle", 8'(busy), 8'd0);
        chk("bp_next", 8'(bus.req_ready), 8'd2);
        bus.req_valid = 2'b00;

        // Reset mid-EXEC.
        @(negedge clk);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b10;
        bus.req_op    = 6'b000_000;
        bus.req_a     = 16'h1100;
        bus.req_b     = 16'h2200;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("mx_busy", 8'(busy), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("mx_rv", 8'(bus.rsp_valid), 8'd0);
        chk("mx_idle", 8'(busy), 8'd0);
        chk("mx_alua", alu_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.rsp_valid != 2'b00) seen++;
            @(negedge clk);
        end
        chk("mx_norsp", 8'(seen), 8'd0);
        bus.req_valid = 2'b11;
        #1;
        chk("mx_first", 8'(bus.req_ready), 8'd1);
        bus.req_valid = 2'b00;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
